// File: rtl/fetch_ifid_stage_pkg.sv
// Shared definitions for the fetch / IF-ID slice: default widths,
// instruction field positions, NOP encoding and the fetch FSM states.
package fetch_ifid_stage_pkg;

    localparam int unsigned INST_W_DEF     = 16;
    localparam int unsigned PC_W_DEF       = 32;
    localparam int unsigned REG_ADDR_W_DEF = 3;

    localparam int unsigned TWO_WORD_BIT = 15;
    localparam int unsigned RSRC_MSB     = 10;
    localparam int unsigned RSRC_LSB     = 8;
    localparam int unsigned RDST_MSB     = 7;
    localparam int unsigned RDST_LSB     = 5;

    localparam logic [INST_W_DEF-1:0] NOP_INST = '0;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_IMM   = 1'b1
    } fetch_state_t;

    // An opcode word with the top marker bit set carries an immediate in the next word.
    function automatic logic is_two_word(input logic [INST_W_DEF-1:0] word);
        return word[TWO_WORD_BIT];
    endfunction

endpackage

// File: rtl/fetch_ifid_stage_pc_unit.sv
// Program counter: async reset to RESET_PC, load target, hold, or increment.
// Increment is modulo 2^PC_W, so all-ones wraps to zero.
module pc_unit
    import fetch_ifid_stage_pkg::*;
#(
    parameter int unsigned      PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold,
    input  logic            load,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus1
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    assign pc       = pc_q;
    assign pc_plus1 = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

    // Next PC: load wins over hold, otherwise step to the following word.
    always_comb begin
        pc_d = pc_plus1;
        if (load) begin
            pc_d = target;
        end else if (hold) begin
            pc_d = pc_q;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_ifid_stage.sv
// Fetch stage plus IF/ID register. Assembles one- or two-word instructions
// (immediate follows the opcode word) and presents register fields to the
// load-use hazard unit. Flush beats stall beats normal advance.
// Optional: define STALL_COUNT_EN to add a saturating stall_count output.
module fetch_ifid_stage
    import fetch_ifid_stage_pkg::*;
#(
    parameter int unsigned      INST_W     = INST_W_DEF,
    parameter int unsigned      PC_W       = PC_W_DEF,
    parameter logic [PC_W-1:0]  RESET_PC   = '0,
    parameter int unsigned      REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_signal,
    input  logic                  flush,
    input  logic [PC_W-1:0]       flush_target,
    output logic [PC_W-1:0]       imem_addr,
    input  logic [INST_W-1:0]     imem_data,
    output logic [INST_W-1:0]     ifid_inst,
    output logic [INST_W-1:0]     ifid_imm,
    output logic [PC_W-1:0]       ifid_pc,
    output logic                  ifid_valid,
    output logic [REG_ADDR_W-1:0] rsrc_ifid,
    output logic [REG_ADDR_W-1:0] rdst_ifid
`ifdef STALL_COUNT_EN
    ,
    output logic [15:0]           stall_count
`endif
);

    fetch_state_t      state_q, state_d;
    logic [INST_W-1:0] hold_q, hold_d;
    logic [INST_W-1:0] ifid_inst_q, ifid_inst_d;
    logic [INST_W-1:0] ifid_imm_q, ifid_imm_d;
    logic [PC_W-1:0]   ifid_pc_q, ifid_pc_d;
    logic              ifid_valid_q, ifid_valid_d;

    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_plus1;
    logic              advance;

    assign advance = !flush && !stall_signal;

    pc_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (stall_signal),
        .load     (flush),
        .target   (flush_target),
        .pc       (pc),
        .pc_plus1 (pc_plus1)
    );

    assign imem_addr  = pc;
    assign ifid_inst  = ifid_inst_q;
    assign ifid_imm   = ifid_imm_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_valid = ifid_valid_q;
    assign rsrc_ifid  = ifid_inst_q[RSRC_MSB:RSRC_LSB];
    assign rdst_ifid  = ifid_inst_q[RDST_MSB:RDST_LSB];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a marked opcode word moves to S_IMM for its immediate.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_FETCH;
        end else if (advance) begin
            case (state_q)
                S_FETCH: state_d = is_two_word(imem_data) ? S_IMM : S_FETCH;
                S_IMM:   state_d = S_FETCH;
            endcase
        end
    end

    // Datapath outputs: hold register and IF/ID next values per state.
    always_comb begin
        hold_d       = hold_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_imm_d   = ifid_imm_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        if (flush) begin
            hold_d       = '0;
            ifid_inst_d  = NOP_INST;
            ifid_imm_d   = '0;
            ifid_valid_d = 1'b0;
        end else if (advance) begin
            case (state_q)
                S_FETCH: begin
                    if (is_two_word(imem_data)) begin
                        // Park the opcode; IF/ID carries a bubble this cycle.
                        hold_d       = imem_data;
                        ifid_inst_d  = NOP_INST;
                        ifid_imm_d   = '0;
                        ifid_valid_d = 1'b0;
                    end else begin
                        ifid_inst_d  = imem_data;
                        ifid_imm_d   = '0;
                        ifid_pc_d    = pc_plus1;
                        ifid_valid_d = 1'b1;
                    end
                end
                S_IMM: begin
                    ifid_inst_d  = hold_q;
                    ifid_imm_d   = imem_data;
                    ifid_pc_d    = pc_plus1;
                    ifid_valid_d = 1'b1;
                end
            endcase
        end
    end

    // Hold register and IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q       <= '0;
            ifid_inst_q  <= '0;
            ifid_imm_q   <= '0;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_imm_q   <= ifid_imm_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

`ifdef STALL_COUNT_EN
    logic [15:0] stall_count_q, stall_count_d;

    assign stall_count = stall_count_q;

    // Count stalled cycles that are not overridden by a flush; saturate.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_signal && !flush && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end
`endif

endmodule
